square_iter_nbit: RTL and testbench

- Parametrised, sequential successor to the team's fixed 4-bit combinational squarer.
- Computes P = A*A for a WIDTH-bit operand using iterative shift-add, one partial product per clock.
- Supports unsigned and two's-complement operands, selected per transaction.
- Sits in the multiplier/arith library as an area-lean squarer with valid/ready handshakes on both sides. Intended for datapaths where latency can be traded for area.

---
 rtl/square_iter_nbit.sv | 116 +++++++++++
 tb/tb_square_iter_nbit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_iter_nbit.sv
// Iterative shift-add squarer: P = A*A, one partial product per clock, signed or unsigned operand.
// Latency: accept edge is edge 0, out_valid rises after edge WIDTH; period WIDTH+2 with out_ready high.
// Backpressure: in_ready only in IDLE; result and out_valid held in DONE until out_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_signed/a operand side;
//        out_valid/out_ready/p result side (p is 2*WIDTH, always non-negative); busy in CALC/DONE.
module square_iter_nbit #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_count;
  logic [2*WIDTH-1:0]   r_p;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_mag;
  logic [2*WIDTH-1:0]   w_acc_nxt;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_count == LAST_CNT);

  // Squaring only needs |a|; the most negative value negates to 2^(WIDTH-1),
  // which is still representable as an unsigned WIDTH-bit magnitude.
  assign w_mag = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;

  // |a| < 2^WIDTH so the running sum never exceeds 2*WIDTH bits.
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_p      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag};
            r_mplier <= w_mag;
            r_count  <= '0;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CNT_W'(1);
          // Fixed latency: no early exit when the multiplier runs out of ones.
          if (w_last) r_p <= w_acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_square_iter_nbit.sv
module tb_square_iter_nbit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  // ---------------- DUT instances: WIDTH = 8, 4, 16 ----------------
  logic        v8 = 0, s8 = 0, ordy8 = 1;
  logic [7:0]  a8 = '0;
  logic        rdy8, ov8, busy8;
  logic [15:0] p8;

  logic        v4 = 0, s4 = 0, ordy4 = 1;
  logic [3:0]  a4 = '0;
  logic        rdy4, ov4, busy4;
  logic [7:0]  p4;

  logic        v16 = 0, s16 = 0, ordy16 = 1;
  logic [15:0] a16 = '0;
  logic        rdy16, ov16, busy16;
  logic [31:0] p16;

  square_iter_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_signed(s8), .a(a8),
    .out_valid(ov8), .out_ready(ordy8), .p(p8), .busy(busy8));

  square_iter_nbit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_signed(s4), .a(a4),
    .out_valid(ov4), .out_ready(ordy4), .p(p4), .busy(busy4));

  square_iter_nbit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .in_signed(s16), .a(a16),
    .out_valid(ov16), .out_ready(ordy16), .p(p16), .busy(busy16));

  // ---------------- scoreboard queues ----------------
  longint q8_p[$],  q8_a[$],  q8_t[$];
  longint q4_p[$],  q4_a[$],  q4_t[$];
  longint q16_p[$], q16_a[$], q16_t[$];
  longint prev_acc16 = -1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: square of the operand's numeric value under the chosen interpretation.
  function automatic longint sq_ref(input longint av, input bit sg, input int w);
    longint v;
    v = av;
    if (sg && av[w-1]) v = av - (longint'(1) << w);
    return v * v;
  endfunction

  task automatic drive(input int w, input bit vld, input longint av, input bit sg);
    case (w)
      4:  begin v4  = vld; a4  = av[3:0];  s4  = sg; end
      8:  begin v8  = vld; a8  = av[7:0];  s8  = sg; end
      default: begin v16 = vld; a16 = av[15:0]; s16 = sg; end
    endcase
  endtask

  function automatic bit get_rdy(input int w);
    case (w)
      4:       return rdy4;
      8:       return rdy8;
      default: return rdy16;
    endcase
  endfunction

  // Presents one operand, waits (bounded) for acceptance, queues the expectation.
  task automatic issue(input int w, input longint av, input bit sg, input bit track);
    int     n;
    longint e, acc_edge;
    n = 0;
    @(posedge clk); #1;
    drive(w, 1'b1, av, sg);
    forever begin
      @(negedge clk);
      if (get_rdy(w)) break;
      n++;
      if (n > 100) begin
        checks++; errs++;
        $display("FAIL accept_timeout w=%0d: got=no in_ready expected=in_ready within 100 cycles", w);
        @(posedge clk); #1;
        drive(w, 1'b0, 0, 1'b0);
        return;
      end
    end
    acc_edge = cyc + 1;
    e = sq_ref(av, sg, w);
    if (track) begin
      case (w)
        4:  begin q4_p.push_back(e);  q4_a.push_back(av);  q4_t.push_back(acc_edge + 4);  end
        8:  begin q8_p.push_back(e);  q8_a.push_back(av);  q8_t.push_back(acc_edge + 8);  end
        default: begin
          q16_p.push_back(e); q16_a.push_back(av); q16_t.push_back(acc_edge + 16);
          if (prev_acc16 >= 0) chk("period16", acc_edge - prev_acc16, 18);
          prev_acc16 = acc_edge;
        end
      endcase
    end
    @(posedge clk); #1;
    // Scramble the operand after acceptance; the DUT must not look at it.
    drive(w, 1'b0, longint'($urandom), 1'($urandom));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q4_p.size() + q8_p.size() + q16_p.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        checks++; errs++;
        $display("FAIL drain_timeout: got=%0d pending expected=0 pending",
                 q4_p.size() + q8_p.size() + q16_p.size());
        q4_p.delete(); q4_a.delete(); q4_t.delete();
        q8_p.delete(); q8_a.delete(); q8_t.delete();
        q16_p.delete(); q16_a.delete(); q16_t.delete();
        return;
      end
    end
  endtask

  // ---------------- monitors ----------------
  logic pov8 = 0, pov4 = 0, pov16 = 0;

  always @(negedge clk) begin
    longint e, ea;
    if (rst_n) begin
      if (ov8 && !pov8 && q8_t.size() != 0) chk("latency8", cyc, q8_t.pop_front());
      if (ov8 && ordy8) begin
        if (q8_p.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected8: got=p 0x%0h expected=no output", p8);
        end else begin
          e = q8_p.pop_front(); ea = q8_a.pop_front();
          chk("p8", p8, e);
          chk("p8_bit1", p8[1], 0);
          chk("p8_bit0", p8[0], ea[0]);
        end
      end
    end
    pov8 = ov8;
  end

  always @(negedge clk) begin
    longint e, ea;
    if (rst_n) begin
      if (ov4 && !pov4 && q4_t.size() != 0) chk("latency4", cyc, q4_t.pop_front());
      if (ov4 && ordy4) begin
        if (q4_p.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected4: got=p 0x%0h expected=no output", p4);
        end else begin
          e = q4_p.pop_front(); ea = q4_a.pop_front();
          chk("p4", p4, e);
          chk("p4_bit1", p4[1], 0);
          chk("p4_bit0", p4[0], ea[0]);
        end
      end
    end
    pov4 = ov4;
  end

  always @(negedge clk) begin
    longint e, ea;
    if (rst_n) begin
      if (ov16 && !pov16 && q16_t.size() != 0) chk("latency16", cyc, q16_t.pop_front());
      if (ov16 && ordy16) begin
        if (q16_p.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected16: got=p 0x%0h expected=no output", p16);
        end else begin
          e = q16_p.pop_front(); ea = q16_a.pop_front();
          chk("p16", p16, e);
          chk("p16_bit1", p16[1], 0);
        end
      end
    end
    pov16 = ov16;
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: got=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] held;
    int          n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready8", rdy8, 1);
    chk("rst_out_valid8", ov8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_p8", p8, 0);
    chk("rst_in_ready16", rdy16, 1);
    chk("rst_p4", p4, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Directed WIDTH=8 operands
    issue(8, 'hFF, 1'b0, 1'b1);
    issue(8, 'h0D, 1'b0, 1'b1);
    issue(8, 'h80, 1'b1, 1'b1);
    issue(8, 'hFF, 1'b1, 1'b1);
    issue(8, 'hFF, 1'b0, 1'b1);
    issue(8, 'h00, 1'b0, 1'b1);
    issue(8, 'h00, 1'b1, 1'b1);
    issue(8, 'h7F, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) issue(8, longint'($urandom_range(0, 255)), 1'($urandom), 1'b1);
    drain();

    // Backpressure: hold the result for 20 cycles while a new operand is offered
    ordy8 = 1'b0;
    issue(8, 'h5A, 1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov8 && n < 50);
    chk("bp_reached_done", ov8, 1);
    held = p8;
    chk("bp_p_value", held, 16'h1FA4);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive(8, 1'b1, longint'($urandom), 1'($urandom));
      @(negedge clk);
      chk("bp_p_stable", p8, held);
      chk("bp_out_valid", ov8, 1);
      chk("bp_in_ready", rdy8, 0);
    end
    @(posedge clk); #1;
    drive(8, 1'b0, 0, 1'b0);
    ordy8 = 1'b1;
    @(negedge clk);             // monitor consumes the result here
    @(negedge clk);
    chk("bp_release_in_ready", rdy8, 1);
    chk("bp_release_out_valid", ov8, 0);
    chk("bp_release_p_held", p8, held);
    drain();

    // Asynchronous reset partway through a calculation
    issue(8, 'h33, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_p", p8, 0);
    chk("midrst_out_valid", ov8, 0);
    chk("midrst_in_ready", rdy8, 1);
    chk("midrst_busy", busy8, 0);
    #7;
    rst_n = 1'b1;
    issue(8, 'h07, 1'b0, 1'b1);
    drain();

    // WIDTH=4 exhaustive, both interpretations
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        issue(4, longint'(i), 1'(s), 1'b1);
    drain();

    // WIDTH=16 random, back-to-back with out_ready high
    for (int i = 0; i < 1000; i++)
      issue(16, longint'($urandom_range(0, 65535)), 1'($urandom), 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
